// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/exception controller:
// FSM encodings, stall vectors, cause codes and the exception vector base.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StFlush  = 2'd1,
      StRefill = 2'd2
   } pc_state_e;

   // Stall vectors: bit0 PC .. bit5 WB; a stage holds along with everything upstream of it.
   localparam logic [5:0] StallNone = 6'b000000;
   localparam logic [5:0] StallId   = 6'b000111;
   localparam logic [5:0] StallEx   = 6'b001111;
   localparam logic [5:0] StallMem  = 6'b011111;

   localparam logic [2:0] ExcpEret = 3'b111;

   localparam logic [31:0] ExcBaseDflt = 32'h0000_0020;

   // Each cause owns an 8-byte slot in the vector table.
   function automatic logic [31:0] vector_addr(input logic [31:0] base, input logic [2:0] cause);
      return base + {26'd0, cause, 3'b000};
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_timer.sv
// Consecutive-stall watchdog: counts back-to-back stalled cycles and raises a
// sticky timeout flag once the run reaches TIMEOUT_CYCLES.
module stall_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall_i,
   output logic timeout_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;

   always_comb begin
      cnt_d     = '0;
      timeout_d = timeout_q;
      if (stall_i) begin
         cnt_d = (cnt_q == CntW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CntW'(1);
         // Flag lands on the same edge that brings the run length to the limit.
         if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: combinational stall priority, one-cycle flush with
// redirect on exception/ERET, a refill bubble, stall statistics and watchdog.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] EXC_BASE       = ExcBaseDflt
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excp_valid,
   input  logic [2:0]  excp_type,
   input  logic [31:0] epc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        timeout_o,
   output logic [15:0] stall_cnt_o
);

   pc_state_e   state_q, state_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [5:0]  stall_req;

   always_comb begin
      stall_req = StallNone;
      if (stallreq_mem) begin
         stall_req = StallMem;
      end else if (stallreq_ex) begin
         stall_req = StallEx;
      end else if (stallreq_id) begin
         stall_req = StallId;
      end
   end

   always_comb begin
      state_d  = state_q;
      flush_d  = 1'b0;
      new_pc_d = new_pc_q;
      stall_o  = StallNone;
      unique case (state_q)
         StRun: begin
            if (excp_valid) begin
               state_d  = StFlush;
               flush_d  = 1'b1;
               new_pc_d = (excp_type == ExcpEret) ? epc_i : vector_addr(EXC_BASE, excp_type);
            end else if (rst_n) begin
               // Gated by rst_n so the hold vector stays clear while reset is applied.
               stall_o = stall_req;
            end
         end
         StFlush:  state_d = StRefill;
         StRefill: state_d = StRun;
         default:  state_d = StRun;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o != StallNone && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         flush_q     <= 1'b0;
         new_pc_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         new_pc_q    <= new_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   stall_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_stall_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall_i  (stall_o != StallNone),
      .timeout_o(timeout_o)
   );

   assign flush_o     = flush_q;
   assign new_pc_o    = new_pc_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
